// File: rtl/load_bfp_reader.sv
// load_bfp_reader: AXI4 read master that fetches block-floating-point tiles.
// Each block is one INCR burst: one exponent beat, then BEATS mantissa beats.
// The beats are unpacked into a shared exponent plus SYST_ARRAY_WIDTH mantissa lanes.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start_i              one-cycle start request, sampled only when idle
//   base_addr_i          beat-aligned byte address of the first block
//   num_blocks_i         number of blocks to fetch (0 completes immediately)
//   busy_o, done_o       not-idle flag, one-cycle completion pulse
//   err_o                sticky read error flag (always 0 unless checking is built in)
//   m_axi_memory_bus_*   AXI4 AR/R channels (single outstanding burst)
//   load_mantissa_o      lane k at bits [k*MW +: MW]
//   load_exponent_o      shared exponent of the block
//   load_valid_o/ready_i block output handshake
//
// Build option: define LOAD_BFP_RRESP_CHECK_EN to check RRESP and RLAST per beat.
// A bad beat sets err_o, drains the rest of the burst, and ends the transfer.
module load_bfp_reader #(
    parameter int unsigned AXI_WIDTH_ID             = 4,
    parameter int unsigned AXI_WIDTH_AD             = 32,
    parameter int unsigned AXI_WIDTH_DA             = 32,
    parameter int unsigned EXPONENT_WIDTH           = 8,
    parameter int unsigned QUNATIZED_MANTISSA_WIDTH = 7,
    parameter int unsigned SYST_ARRAY_WIDTH         = 32
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start_i,
    input  logic [AXI_WIDTH_AD-1:0]                              base_addr_i,
    input  logic [15:0]                                          num_blocks_i,
    output logic                                                 busy_o,
    output logic                                                 done_o,
    output logic                                                 err_o,
    output logic [AXI_WIDTH_ID-1:0]                              m_axi_memory_bus_ARID,
    output logic [AXI_WIDTH_AD-1:0]                              m_axi_memory_bus_ARADDR,
    output logic [7:0]                                           m_axi_memory_bus_ARLEN,
    output logic [2:0]                                           m_axi_memory_bus_ARSIZE,
    output logic [1:0]                                           m_axi_memory_bus_ARBURST,
    output logic                                                 m_axi_memory_bus_ARVALID,
    input  logic                                                 m_axi_memory_bus_ARREADY,
    input  logic [AXI_WIDTH_ID-1:0]                              m_axi_memory_bus_RID,
    input  logic [AXI_WIDTH_DA-1:0]                              m_axi_memory_bus_RDATA,
    input  logic [1:0]                                           m_axi_memory_bus_RRESP,
    input  logic                                                 m_axi_memory_bus_RLAST,
    input  logic                                                 m_axi_memory_bus_RVALID,
    output logic                                                 m_axi_memory_bus_RREADY,
    output logic [SYST_ARRAY_WIDTH*QUNATIZED_MANTISSA_WIDTH-1:0] load_mantissa_o,
    output logic [EXPONENT_WIDTH-1:0]                            load_exponent_o,
    output logic                                                 load_valid_o,
    input  logic                                                 load_ready_i
);

    localparam int unsigned BYTES  = AXI_WIDTH_DA / 8;
    localparam int unsigned BEATS  = SYST_ARRAY_WIDTH / BYTES;
    localparam int unsigned STRIDE = (BEATS + 1) * BYTES;
    localparam int unsigned MW     = QUNATIZED_MANTISSA_WIDTH;

    typedef enum logic [2:0] {StIdle, StAr, StRd, StOut, StDone} state_e;

    state_e                       state_q, state_d;
    logic [AXI_WIDTH_AD-1:0]      addr_q;
    logic [15:0]                  blocks_q;
    logic [7:0]                   beat_q;
    logic [EXPONENT_WIDTH-1:0]    exp_q;
    logic [SYST_ARRAY_WIDTH*MW-1:0] mant_q;

    logic r_fire;
    logic last_beat;
    logic abort;         // current burst is bad: keep draining, skip OUT
    logic unused_inputs;

    assign r_fire    = (state_q == StRd) && m_axi_memory_bus_RVALID;
    // The beat counter, not RLAST, marks the end of the burst.
    assign last_beat = (beat_q == 8'(BEATS));

    // Constant AR fields.
    assign m_axi_memory_bus_ARID    = '0;
    assign m_axi_memory_bus_ARLEN   = 8'(BEATS);
    assign m_axi_memory_bus_ARSIZE  = 3'($clog2(BYTES));
    assign m_axi_memory_bus_ARBURST = 2'b01;
    assign m_axi_memory_bus_ARADDR  = addr_q;

    assign load_mantissa_o = mant_q;
    assign load_exponent_o = exp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d                 = state_q;
        busy_o                  = (state_q != StIdle);
        done_o                  = 1'b0;
        m_axi_memory_bus_ARVALID = 1'b0;
        m_axi_memory_bus_RREADY = 1'b0;
        load_valid_o            = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (num_blocks_i == 16'd0) ? StDone : StAr;
                end
            end
            StAr: begin
                m_axi_memory_bus_ARVALID = 1'b1;
                if (m_axi_memory_bus_ARREADY) begin
                    state_d = StRd;
                end
            end
            StRd: begin
                m_axi_memory_bus_RREADY = 1'b1;
                if (r_fire && last_beat) begin
                    state_d = abort ? StDone : StOut;
                end
            end
            StOut: begin
                load_valid_o = 1'b1;
                if (load_ready_i) begin
                    state_d = (blocks_q == 16'd1) ? StDone : StAr;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            blocks_q <= '0;
            beat_q   <= '0;
            exp_q    <= '0;
            mant_q   <= '0;
        end else begin
            if (state_q == StIdle && start_i && num_blocks_i != 16'd0) begin
                addr_q   <= base_addr_i;
                blocks_q <= num_blocks_i;
                beat_q   <= '0;
            end
            if (r_fire) begin
                beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
                if (!abort) begin
                    if (beat_q == 8'd0) begin
                        exp_q <= m_axi_memory_bus_RDATA[EXPONENT_WIDTH-1:0];
                    end
                    // Byte j of mantissa beat b lands in lane (b-1)*BYTES+j; the
                    // byte bits above the mantissa are dropped.
                    for (int k = 0; k < int'(SYST_ARRAY_WIDTH); k++) begin
                        if (int'(beat_q) == k / int'(BYTES) + 1) begin
                            mant_q[k*MW +: MW] <=
                                m_axi_memory_bus_RDATA[(k % int'(BYTES))*8 +: MW];
                        end
                    end
                end
            end
            if (state_q == StOut && load_ready_i) begin
                blocks_q <= blocks_q - 16'd1;
                addr_q   <= addr_q + AXI_WIDTH_AD'(STRIDE);
            end
        end
    end

`ifdef LOAD_BFP_RRESP_CHECK_EN
    logic err_q;
    logic drain_q;
    logic beat_err;

    assign beat_err = (m_axi_memory_bus_RRESP != 2'b00) || (m_axi_memory_bus_RLAST != last_beat);
    assign abort    = drain_q || beat_err;
    assign err_o    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            if (state_q == StIdle && start_i) begin
                err_q <= 1'b0;
            end
            if (r_fire && beat_err) begin
                err_q <= 1'b1;
            end
            if (r_fire) begin
                drain_q <= last_beat ? 1'b0 : (drain_q || beat_err);
            end
        end
    end

    assign unused_inputs = ^{m_axi_memory_bus_RID, m_axi_memory_bus_RDATA};
`else
    assign abort         = 1'b0;
    assign err_o         = 1'b0;
    assign unused_inputs = ^{m_axi_memory_bus_RID, m_axi_memory_bus_RDATA,
                             m_axi_memory_bus_RRESP, m_axi_memory_bus_RLAST};
`endif

endmodule

// File: tb/tb_load_bfp_reader.sv
// Self-checking bench for load_bfp_reader: AXI slave model over a byte memory,
// expected tiles computed directly from the memory contents.
module tb_load_bfp_reader;

    localparam int BYTES = 4;
    localparam int BEATS = 8;
    localparam int SW    = 32;
    localparam int MW    = 7;
    localparam int EW    = 8;
    localparam int STR   = (BEATS + 1) * BYTES;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       base_addr;
    logic [15:0]       num_blocks;
    logic              busy, done, err;
    logic [3:0]        arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid, arready;
    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;
    logic [SW*MW-1:0]  mant;
    logic [EW-1:0]     expo;
    logic              load_valid, load_ready;

    load_bfp_reader dut (
        .clk                      (clk),
        .rst                      (rst),
        .start_i                  (start),
        .base_addr_i              (base_addr),
        .num_blocks_i             (num_blocks),
        .busy_o                   (busy),
        .done_o                   (done),
        .err_o                    (err),
        .m_axi_memory_bus_ARID    (arid),
        .m_axi_memory_bus_ARADDR  (araddr),
        .m_axi_memory_bus_ARLEN   (arlen),
        .m_axi_memory_bus_ARSIZE  (arsize),
        .m_axi_memory_bus_ARBURST (arburst),
        .m_axi_memory_bus_ARVALID (arvalid),
        .m_axi_memory_bus_ARREADY (arready),
        .m_axi_memory_bus_RID     (rid),
        .m_axi_memory_bus_RDATA   (rdata),
        .m_axi_memory_bus_RRESP   (rresp),
        .m_axi_memory_bus_RLAST   (rlast),
        .m_axi_memory_bus_RVALID  (rvalid),
        .m_axi_memory_bus_RREADY  (rready),
        .load_mantissa_o          (mant),
        .load_exponent_o          (expo),
        .load_valid_o             (load_valid),
        .load_ready_i             (load_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Byte-addressed memory backing the slave.
    logic [7:0] mem [0:16383];

    function automatic logic [SW*MW-1:0] model_lanes(input int a);
        logic [SW*MW-1:0] v;
        v = '0;
        for (int k = 0; k < SW; k++) v[k*MW +: MW] = mem[a + BYTES + k][MW-1:0];
        return v;
    endfunction

    // Slave configuration, set by the main sequence.
    int ar_delay   = 0;
    bit toggle     = 0;
    int err_beat   = -1;
    bit slave_flush = 0;

    // AXI slave: drives inputs on negedge, learns about handshakes one cycle later.
    initial begin
        int  ar_wait, sbeat, burst_addr, pend_addr;
        bit  in_burst, ar_pend, r_pend, phase;
        ar_wait = 0; sbeat = 0; burst_addr = 0; pend_addr = 0;
        in_burst = 0; ar_pend = 0; r_pend = 0; phase = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0;
        forever begin
            @(negedge clk);
            if (slave_flush) begin
                in_burst = 0; ar_pend = 0; r_pend = 0; ar_wait = 0;
            end
            if (ar_pend) begin
                in_burst = 1; sbeat = 0; burst_addr = pend_addr; ar_wait = 0; phase = 0;
            end
            if (r_pend) begin
                sbeat++;
                if (sbeat > BEATS) in_burst = 0;
            end
            arready = 0;
            if (!in_burst && arvalid) begin
                if (ar_wait >= ar_delay) arready = 1;
                else ar_wait++;
            end
            rvalid = 0; rlast = 0; rresp = 2'b00;
            if (in_burst) begin
                rvalid = toggle ? !phase : 1'b1;
                phase  = !phase;
                for (int j = 0; j < BYTES; j++) rdata[j*8 +: 8] = mem[burst_addr + sbeat*BYTES + j];
                rlast = (sbeat == BEATS);
                rresp = (sbeat == err_beat) ? 2'b10 : 2'b00;
            end
            ar_pend   = arvalid && arready;
            pend_addr = int'(araddr);
            r_pend    = rvalid && rready;
        end
    end

    // Monitor: AR log, beat/done counters, AR stability while waiting.
    int          cyc = 0;
    int          last_r_cyc = -10;
    int          r_beats = 0;
    int          done_cnt = 0;
    logic [31:0] ar_log [$];
    bit          arv_wait = 0;
    logic [31:0] addr_prev = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (arvalid && arready) ar_log.push_back(araddr);
            if (rvalid && rready) begin
                last_r_cyc <= cyc;
                r_beats    <= r_beats + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (arv_wait) begin
                chk("arvalid_held", arvalid, 1'b1);
                chk("araddr_stable", araddr, addr_prev);
            end
        end
        arv_wait  <= !rst && arvalid && !arready;
        addr_prev <= araddr;
    end

    task automatic run_xfer(input int base, input int n, input int stall_blk, input int stall_len);
        int d0;
        bit ok;
        ar_log.delete();
        d0 = done_cnt;
        base_addr = 32'(base); num_blocks = 16'(n); start = 1;
        tick();
        start = 0;
        for (int b = 0; b < n; b++) begin
            ok = 0;
            for (int t = 0; t < 300 && !ok; t++) begin
                if (load_valid) ok = 1;
                else tick();
            end
            chk("valid_seen", ok, 1'b1);
            if (!ok) return;
            chk("valid_latency", cyc, last_r_cyc + 1);
            for (int s = 0; s < ((b == stall_blk) ? stall_len : 0); s++) begin
                chk("stall_lanes", mant, model_lanes(base + b*STR));
                chk("stall_exp", expo, mem[base + b*STR]);
                chk("stall_valid", load_valid, 1'b1);
                chk("stall_no_ar", arvalid, 1'b0);
                tick();
            end
            chk("lanes", mant, model_lanes(base + b*STR));
            chk("exponent", expo, mem[base + b*STR]);
            load_ready = 1;
            tick();
            load_ready = 0;
        end
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (done) ok = 1;
            else tick();
        end
        chk("done_seen", ok, 1'b1);
        tick();
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after", busy, 1'b0);
        chk("done_count", done_cnt - d0, 1);
        chk("ar_count", ar_log.size(), n);
        for (int i = 0; i < ar_log.size(); i++) chk("araddr", ar_log[i], 32'(base + i*STR));
    endtask

    task automatic fill_pattern();
        for (int a = 0; a < 16384; a++) mem[a] = 8'h00;
        mem[32'h1000] = 8'h85;
        for (int k = 0; k < SW; k++) mem[32'h1004 + k] = 8'(k + 1);
    endtask

    initial begin
        rst = 1; start = 0; base_addr = '0; num_blocks = '0; load_ready = 0;
        fill_pattern();
        repeat (3) tick();
        rst = 0;
        // Reset state and constant AR fields.
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_valid", load_valid, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_mant", mant, '0);
        chk("rst_exp", expo, '0);
        chk("arid", arid, '0);
        chk("arlen", arlen, BEATS);
        chk("arsize", arsize, 2);
        chk("arburst", arburst, 2'b01);

        // Single block, known pattern, ARREADY immediate.
        run_xfer(32'h1000, 1, -1, 0);
        chk("lane_k_plus_1", mant[5*MW +: MW], 7'd6);
        chk("no_err", err, 1'b0);

        // Three blocks, stall on block 2.
        for (int a = 32'h1000; a < 32'h1000 + 3*STR; a++) mem[a] = 8'($urandom);
        run_xfer(32'h1000, 3, 1, 5);

        // Zero blocks: straight to DONE.
        base_addr = 32'h1000; num_blocks = 0; start = 1;
        tick();
        start = 0;
        chk("zero_busy", busy, 1'b1);
        chk("zero_done", done, 1'b1);
        chk("zero_arvalid", arvalid, 1'b0);
        tick();
        chk("zero_busy_end", busy, 1'b0);
        chk("zero_done_end", done, 1'b0);

        // Throttled R channel and delayed ARREADY.
        fill_pattern();
        ar_delay = 4; toggle = 1;
        run_xfer(32'h1000, 1, -1, 0);
        ar_delay = 0; toggle = 0;

        // All-ones bytes: mantissa MSB dropped.
        for (int a = 32'h1000; a < 32'h1000 + STR; a++) mem[a] = 8'hFF;
        run_xfer(32'h1000, 1, -1, 0);
        chk("all_7f_lane31", mant[31*MW +: MW], 7'h7F);

        // Randomized transfers.
        for (int r = 0; r < 3; r++) begin
            int base;
            base = 32'h1000 + 4 * int'($urandom_range(0, 200));
            for (int a = base; a < base + 3*STR; a++) mem[a] = 8'($urandom);
            ar_delay = int'($urandom_range(0, 3));
            toggle   = 1'($urandom_range(0, 1));
            run_xfer(base, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)), 2);
        end
        ar_delay = 0; toggle = 0;

`ifdef LOAD_BFP_RRESP_CHECK_EN
        begin
            int  b0, vseen;
            bit  ok;
            err_beat = 3;
            ar_log.delete();
            b0 = r_beats; vseen = 0;
            base_addr = 32'h1000; num_blocks = 2; start = 1;
            tick();
            start = 0;
            ok = 0;
            for (int t = 0; t < 200 && !ok; t++) begin
                if (load_valid) vseen++;
                if (done) ok = 1;
                else tick();
            end
            chk("err_done_seen", ok, 1'b1);
            chk("err_no_valid", vseen, 0);
            chk("err_drained", r_beats - b0, BEATS + 1);
            chk("err_one_burst", ar_log.size(), 1);
            chk("err_set", err, 1'b1);
            tick();
            chk("err_sticky", err, 1'b1);
            // Restart, then reset mid-burst after the error.
            b0 = r_beats;
            base_addr = 32'h1000; num_blocks = 1; start = 1;
            tick();
            start = 0;
            ok = 0;
            for (int t = 0; t < 100 && !ok; t++) begin
                if (r_beats - b0 >= 5) ok = 1;
                else tick();
            end
            chk("err_mid_reached", ok, 1'b1);
            chk("err_mid_set", err, 1'b1);
            rst = 1; slave_flush = 1;
            tick();
            rst = 0;
            chk("rst_mid_err", err, 1'b0);
            chk("rst_mid_busy", busy, 1'b0);
            chk("rst_mid_rready", rready, 1'b0);
            chk("rst_mid_valid", load_valid, 1'b0);
            tick();
            tick();
            slave_flush = 0;
            err_beat = -1;
        end
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
